harmonic_accumulator: RTL and testbench
=======================================

Name: harmonic_accumulator

Overview:
- Initiator side of the harmonic scaling handshake: drives start/restart to the scaling-multiple responder, waits on its ready, and consumes the multiple.
- Per output sample, walks harmonics 0..HARM_COUNT-1: requests each harmonic's sine value, multiplies it by the current scaling multiple, and accumulates.
- Emits one saturated signed sample per sample period to the DAC output path.

Parameters:
- DIV_BIT, 11, width of the scaling multiple.
- SAMPLE_BIT, 16, width of the signed harmonic input and of the output sample.
- HARM_BIT, 8, width of the harmonic index.
- HARM_COUNT, 200, number of harmonics summed per sample (at most 2^HARM_BIT).
- ACC_BIT, 32, signed accumulator width.
- OUT_SHIFT, 11, right shift applied to the accumulator before saturation.

Ports:
- i_Clock  in  1  system clock.
- i_Reset_N  in  1  asynchronous active-low reset.
- i_Sample_Clock  in  1  one-cycle pulse that starts a sample period.
- o_Mult_Start  out  1  one-cycle pulse: responder steps the multiple down.
- o_Mult_Restart  out  1  one-cycle pulse: responder reloads the initial multiple.
- i_Mult  in  DIV_BIT  current scaling multiple, unsigned.
- i_Mult_Ready  in  1  responder idle, i_Mult valid.
- o_Harm_Req  out  1  one-cycle pulse requesting the sine value for o_Harm_Index.
- o_Harm_Index  out  HARM_BIT  harmonic being requested.
- i_Harm_Sample  in  SAMPLE_BIT  signed sine value.
- i_Harm_Valid  in  1  i_Harm_Sample valid; one-cycle pulse, any latency after o_Harm_Req.
- o_Sample  out  SAMPLE_BIT  signed output sample, held between updates.
- o_Sample_Valid  out  1  one-cycle pulse when o_Sample updates.
- o_Busy  out  1  high from sample start until the output pulse.

Behaviour:
- Reset (async, i_Reset_N=0):
  - All outputs 0, accumulator 0, index 0, state IDLE.
  - Asserting reset mid-sample aborts the sample with no o_Sample_Valid.
- States: IDLE, RESTART, REQ, WAIT, MAC, OUTPUT.
- IDLE: on i_Sample_Clock, clear accumulator, set index to 0 and o_Busy to 1, go to RESTART.
- RESTART: o_Mult_Restart=1 for exactly one cycle, then go to REQ.
- REQ:
  - o_Harm_Req=1 for one cycle with o_Harm_Index=index.
  - i_Mult_Ready is not sampled in this cycle; this covers the responder's one-cycle ready drop after a start.
  - Go to WAIT.
- WAIT:
  - Latch i_Harm_Sample when i_Harm_Valid=1.
  - Stay in WAIT until the sample has been latched and i_Mult_Ready=1 in the same or a later cycle, then go to MAC.
  - i_Harm_Valid may arrive before or after ready.
- MAC:
  - acc <= acc + (harm_sample x {1'b0, i_Mult}), signed; the product is SAMPLE_BIT+DIV_BIT+1 bits, sign-extended to ACC_BIT.
  - Accumulator wraps on overflow, with no saturation inside the loop.
  - Same cycle: if index==HARM_COUNT-1, go to OUTPUT with no o_Mult_Start.
  - Otherwise pulse o_Mult_Start for one cycle, increment index, go to REQ.
- OUTPUT:
  - o_Sample <= saturate(acc >>> OUT_SHIFT) to SAMPLE_BIT, clamped to [-2^(SAMPLE_BIT-1), 2^(SAMPLE_BIT-1)-1].
  - o_Sample_Valid=1 for one cycle, o_Busy <= 0, go to IDLE.
- Latency:
  - Minimum 3 cycles per harmonic (REQ, WAIT, MAC) when valid and ready are immediate.
  - Sample start to o_Sample_Valid = 2 + 3*HARM_COUNT cycles minimum.
- i_Sample_Clock arriving while o_Busy=1 is ignored; the sample in progress completes unaffected.
- i_Sample_Clock in the same cycle as OUTPUT is ignored, since the state is not yet IDLE.
- A zero multiple is still accumulated, contributing 0.

Optional Feature:
- Macro: HARM_EARLY_TERM_EN.
- Defined: in MAC, if i_Mult==0, the current term is skipped (adds 0), no o_Mult_Start is issued, and the state goes straight to OUTPUT. Remaining harmonics are not requested.
- Undefined: all HARM_COUNT harmonics are always processed.
- o_Sample values are identical either way; only latency differs.

Test Plan:
1. HARM_COUNT=4, responder loads initial 1024 and subtracts 256, every i_Harm_Sample=+1000, immediate valid/ready -> multiples 1024/768/512/256; acc=2,560,000; o_Sample=1250; o_Sample_Valid exactly 14 cycles after i_Sample_Clock; 3 o_Mult_Start pulses, 1 o_Mult_Restart pulse.
2. Same setup, i_Harm_Sample=+32767, OUT_SHIFT=0 -> o_Sample saturates to 32767; with -32768 -> o_Sample=-32768.
3. i_Harm_Valid delayed 5 cycles, and i_Mult_Ready held low 3 extra cycles after valid -> MAC occurs only after both; result matches scenario 1; no extra o_Harm_Req.
4. i_Sample_Clock pulsed again at cycle 6 of a sample -> ignored; single o_Sample_Valid; next sample starts only on a pulse seen in IDLE.
5. i_Reset_N asserted at cycle 8 of a sample -> outputs, o_Busy and o_Harm_Index go to 0 asynchronously; no o_Sample_Valid; the next i_Sample_Clock runs a full clean sample.
6. HARM_EARLY_TERM_EN defined, initial 512, step 256, HARM_COUNT=8, samples +1000 -> two nonzero terms, stop at the third (multiple 0); o_Sample=375; o_Sample_Valid 11 cycles after i_Sample_Clock; no fourth o_Harm_Req.

Source files
------------

// File: rtl/harmonic_accumulator.sv
// Harmonic accumulator: walks HARM_COUNT harmonics per sample and emits one saturated sample.
// Optional HARM_EARLY_TERM_EN ends the harmonic walk as soon as the scaling multiple reaches zero.
//
// state   | meaning
// IDLE    | waiting for i_Sample_Clock
// RESTART | one-cycle restart pulse to the multiple responder
// REQ     | one-cycle sine request for the current harmonic index
// WAIT    | collecting the sine value and waiting for the multiple to be ready
// MAC     | multiply-accumulate, then next harmonic or finish
// OUTPUT  | one-cycle valid pulse with the freshly saturated sample
module harmonic_accumulator #(
    parameter int DIV_BIT    = 11,
    parameter int SAMPLE_BIT = 16,
    parameter int HARM_BIT   = 8,
    parameter int HARM_COUNT = 200,
    parameter int ACC_BIT    = 32,
    parameter int OUT_SHIFT  = 11
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset_N,
    input  logic                  i_Sample_Clock,
    output logic                  o_Mult_Start,
    output logic                  o_Mult_Restart,
    input  logic [DIV_BIT-1:0]    i_Mult,
    input  logic                  i_Mult_Ready,
    output logic                  o_Harm_Req,
    output logic [HARM_BIT-1:0]   o_Harm_Index,
    input  logic [SAMPLE_BIT-1:0] i_Harm_Sample,
    input  logic                  i_Harm_Valid,
    output logic [SAMPLE_BIT-1:0] o_Sample,
    output logic                  o_Sample_Valid,
    output logic                  o_Busy
);

    localparam int PROD_W = SAMPLE_BIT + DIV_BIT + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESTART,
        S_REQ,
        S_WAIT,
        S_MAC,
        S_OUTPUT
    } state_t;

    state_t                       state_q, state_d;
    logic [HARM_BIT-1:0]          index_q, index_d;
    logic signed [ACC_BIT-1:0]    acc_q, acc_d;
    logic signed [SAMPLE_BIT-1:0] harm_q, harm_d;
    logic                         harm_have_q, harm_have_d;
    logic [SAMPLE_BIT-1:0]        sample_q, sample_d;

    logic                         last_harm;
    logic                         early_stop;
    logic                         finish;
    logic signed [PROD_W-1:0]     harm_ext;
    logic signed [PROD_W-1:0]     mult_ext;
    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_BIT-1:0]    term;

    assign last_harm = (index_q == HARM_BIT'(HARM_COUNT - 1));

`ifdef HARM_EARLY_TERM_EN
    assign early_stop = (i_Mult == '0);
`else
    assign early_stop = 1'b0;
`endif

    assign finish = last_harm || early_stop;

    // The multiple is unsigned, so it gets a zero sign bit before the signed multiply.
    assign harm_ext = {{(PROD_W - SAMPLE_BIT){harm_q[SAMPLE_BIT-1]}}, harm_q};
    assign mult_ext = {{(PROD_W - DIV_BIT){1'b0}}, i_Mult};
    assign prod     = harm_ext * mult_ext;
    assign term     = {{(ACC_BIT - PROD_W){prod[PROD_W-1]}}, prod};

    function automatic logic [SAMPLE_BIT-1:0] saturate(input logic signed [ACC_BIT-1:0] a);
        logic signed [ACC_BIT-1:0]      s;
        logic [ACC_BIT-SAMPLE_BIT:0]    upper;
        s     = a >>> OUT_SHIFT;
        upper = s[ACC_BIT-1:SAMPLE_BIT-1];
        if ((&upper) || (~|upper)) begin
            saturate = s[SAMPLE_BIT-1:0];
        end else if (s[ACC_BIT-1]) begin
            saturate = {1'b1, {(SAMPLE_BIT - 1){1'b0}}};
        end else begin
            saturate = {1'b0, {(SAMPLE_BIT - 1){1'b1}}};
        end
    endfunction

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (i_Sample_Clock) state_d = S_RESTART;
            S_RESTART: state_d = S_REQ;
            S_REQ:     state_d = S_WAIT;
            S_WAIT:    if ((harm_have_q || i_Harm_Valid) && i_Mult_Ready) state_d = S_MAC;
            S_MAC:     state_d = finish ? S_OUTPUT : S_REQ;
            S_OUTPUT:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_Mult_Restart = (state_q == S_RESTART);
        o_Harm_Req     = (state_q == S_REQ);
        o_Mult_Start   = (state_q == S_MAC) && !finish;
        o_Sample_Valid = (state_q == S_OUTPUT);
        o_Busy         = (state_q != S_IDLE);
        o_Harm_Index   = index_q;
        o_Sample       = sample_q;
    end

    // The output register loads on the final MAC so the sample is already valid during OUTPUT.
    always_comb begin
        acc_d       = acc_q;
        index_d     = index_q;
        harm_d      = harm_q;
        harm_have_d = harm_have_q;
        sample_d    = sample_q;
        case (state_q)
            S_IDLE: begin
                if (i_Sample_Clock) begin
                    acc_d   = '0;
                    index_d = '0;
                end
            end
            S_REQ: harm_have_d = 1'b0;
            S_WAIT: begin
                if (i_Harm_Valid) begin
                    harm_d      = i_Harm_Sample;
                    harm_have_d = 1'b1;
                end
            end
            S_MAC: begin
                acc_d = acc_q + term;
                if (finish) begin
                    sample_d = saturate(acc_d);
                end else begin
                    index_d = index_q + {{(HARM_BIT - 1){1'b0}}, 1'b1};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            acc_q       <= '0;
            index_q     <= '0;
            harm_q      <= '0;
            harm_have_q <= 1'b0;
            sample_q    <= '0;
        end else begin
            acc_q       <= acc_d;
            index_q     <= index_d;
            harm_q      <= harm_d;
            harm_have_q <= harm_have_d;
            sample_q    <= sample_d;
        end
    end

endmodule

// File: tb/tb_harmonic_accumulator.sv
// Directed bench for harmonic_accumulator with a behavioural multiple responder and sine source.
module tb_harmonic_accumulator;

`ifdef HARM_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        sc;
    logic        mult_start, mult_restart;
    logic [10:0] mult;
    logic        mult_ready;
    logic        harm_req;
    logic [7:0]  harm_index;
    logic [15:0] harm_sample;
    logic        harm_valid;
    logic [15:0] sample;
    logic        sample_valid;
    logic        busy;

    harmonic_accumulator #(.HARM_COUNT(4)) dut (
        .i_Clock        (clk),
        .i_Reset_N      (rst_n),
        .i_Sample_Clock (sc),
        .o_Mult_Start   (mult_start),
        .o_Mult_Restart (mult_restart),
        .i_Mult         (mult),
        .i_Mult_Ready   (mult_ready),
        .o_Harm_Req     (harm_req),
        .o_Harm_Index   (harm_index),
        .i_Harm_Sample  (harm_sample),
        .i_Harm_Valid   (harm_valid),
        .o_Sample       (sample),
        .o_Sample_Valid (sample_valid),
        .o_Busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [10:0]        cfg_init, cfg_step;
    logic signed [15:0] harm_val;
    int                 harm_delay, ready_extra;
    int                 rcnt, hcnt;
    logic               pending, hv;

    assign mult_ready  = (rcnt == 0);
    assign harm_valid  = hv;
    assign harm_sample = hv ? harm_val : 16'h5A5A;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult    <= '0;
            rcnt    <= 0;
            hcnt    <= 0;
            pending <= 1'b0;
            hv      <= 1'b0;
        end else begin
            hv <= 1'b0;
            if (rcnt != 0) rcnt <= rcnt - 1;
            if (mult_restart) mult <= cfg_init;
            if (mult_start) begin
                mult <= (mult < cfg_step) ? 11'd0 : mult - cfg_step;
                rcnt <= 1;
            end
            if (harm_req) begin
                if (harm_delay == 0) begin
                    hv <= 1'b1;
                    if (ready_extra > 0) rcnt <= ready_extra + 1;
                end else begin
                    pending <= 1'b1;
                    hcnt    <= harm_delay - 1;
                end
            end else if (pending) begin
                if (hcnt == 0) begin
                    hv      <= 1'b1;
                    pending <= 1'b0;
                    if (ready_extra > 0) rcnt <= ready_extra + 1;
                end else begin
                    hcnt <= hcnt - 1;
                end
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_sample(input int repulse_cyc, input bit pulse_at_out,
                              output int lat, output int smp, output int n_start,
                              output int n_restart, output int n_req, output bit timeout);
        @(negedge clk);
        sc        = 1'b1;
        lat       = 0;
        smp       = 0;
        n_start   = 0;
        n_restart = 0;
        n_req     = 0;
        timeout   = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            sc = (c == repulse_cyc);
            n_start   += int'(mult_start);
            n_restart += int'(mult_restart);
            n_req     += int'(harm_req);
            if (sample_valid) begin
                lat     = c;
                smp     = int'($signed(sample));
                timeout = 1'b0;
                if (pulse_at_out) sc = 1'b1;
                break;
            end
        end
        @(negedge clk);
        sc = 1'b0;
    endtask

    typedef struct {
        logic [10:0]        init;
        logic [10:0]        step;
        logic signed [15:0] harm;
        int                 exp_sample;
        int                 lat;
        int                 starts;
        int                 reqs;
    } vec_t;

    vec_t vecs[8];

    int lat, smp, n_start, n_restart, n_req, extra;
    bit timeout;

    initial begin
        vecs[0] = '{11'd1024, 11'd256,  16'sd1000,    1250,   14, 3, 4};
        vecs[1] = '{11'd1024, 11'd256,  16'sd32767,   32767,  14, 3, 4};
        vecs[2] = '{11'd1024, 11'd256, -16'sd32768,  -32768,  14, 3, 4};
        vecs[3] = '{11'd512,  11'd256,  16'sd1000,    375,    ET ? 11 : 14, ET ? 2 : 3, ET ? 3 : 4};
        vecs[4] = '{11'd1024, 11'd256, -16'sd1000,   -1250,   14, 3, 4};
        vecs[5] = '{11'd0,    11'd0,    16'sd1000,    0,      ET ? 5 : 14,  ET ? 0 : 3, ET ? 1 : 4};
        vecs[6] = '{11'd256,  11'd64,   16'sd500,     156,    14, 3, 4};
        vecs[7] = '{11'd1024, 11'd256, -16'sd7,      -9,      14, 3, 4};

        rst_n       = 1'b0;
        sc          = 1'b0;
        cfg_init    = '0;
        cfg_step    = '0;
        harm_val    = '0;
        harm_delay  = 0;
        ready_extra = 0;
        #1;
        check("reset_busy",    int'(busy), 0);
        check("reset_sample",  int'(sample), 0);
        check("reset_valid",   int'(sample_valid), 0);
        check("reset_pulses",  int'(harm_req) + int'(mult_start) + int'(mult_restart), 0);
        check("reset_index",   int'(harm_index), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            cfg_init = vecs[v].init;
            cfg_step = vecs[v].step;
            harm_val = vecs[v].harm;
            run_sample(-1, 1'b0, lat, smp, n_start, n_restart, n_req, timeout);
            check($sformatf("v%0d_timeout", v), int'(timeout), 0);
            check($sformatf("v%0d_sample", v), smp, vecs[v].exp_sample);
            check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
            check($sformatf("v%0d_starts", v), n_start, vecs[v].starts);
            check($sformatf("v%0d_restarts", v), n_restart, 1);
            check($sformatf("v%0d_reqs", v), n_req, vecs[v].reqs);
            check($sformatf("v%0d_idle_busy", v), int'(busy), 0);
            check($sformatf("v%0d_held", v), int'($signed(sample)), vecs[v].exp_sample);
        end

        // Late sine value plus ready held low after it.
        cfg_init    = 11'd1024;
        cfg_step    = 11'd256;
        harm_val    = 16'sd1000;
        harm_delay  = 5;
        ready_extra = 3;
        run_sample(-1, 1'b0, lat, smp, n_start, n_restart, n_req, timeout);
        check("slow_timeout", int'(timeout), 0);
        check("slow_sample",  smp, 1250);
        check("slow_latency", lat, 50);
        check("slow_reqs",    n_req, 4);
        check("slow_starts",  n_start, 3);
        harm_delay  = 0;
        ready_extra = 0;

        // Sample clock while busy and during OUTPUT must be ignored.
        harm_val = 16'sd2000;
        run_sample(6, 1'b1, lat, smp, n_start, n_restart, n_req, timeout);
        check("busy_timeout", int'(timeout), 0);
        check("busy_sample",  smp, 2500);
        check("busy_latency", lat, 14);
        check("busy_reqs",    n_req, 4);
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            extra += int'(sample_valid) + int'(busy);
        end
        check("busy_no_rerun", extra, 0);

        // Asynchronous reset in the middle of a sample.
        harm_val = 16'sd1000;
        @(negedge clk);
        sc = 1'b1;
        @(negedge clk);
        sc = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_reset_index", int'(harm_index), 2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy",   int'(busy), 0);
        check("rst_index",  int'(harm_index), 0);
        check("rst_sample", int'(sample), 0);
        check("rst_req",    int'(harm_req), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            extra += int'(sample_valid) + int'(busy);
        end
        check("rst_no_valid", extra, 0);
        run_sample(-1, 1'b0, lat, smp, n_start, n_restart, n_req, timeout);
        check("post_rst_timeout", int'(timeout), 0);
        check("post_rst_sample",  smp, 1250);
        check("post_rst_latency", lat, 14);
        check("post_rst_restart", n_restart, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
